// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings and digit blank masks for the clock controller.
// The display formatter imports the same mask constants so digit order stays consistent.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    // Digit order {h1,h0,m1,m0,s1,s0}; a set bit blanks that digit.
    localparam logic [5:0] MASK_NONE = 6'b000000;
    localparam logic [5:0] MASK_HOUR = 6'b110000;
    localparam logic [5:0] MASK_MIN  = 6'b001100;

    // Blank the field being edited during the off half of the blink period.
    function automatic logic [5:0] blank_for(input mode_t mode, input logic blink_on);
        logic [5:0] mask;
        mask = MASK_NONE;
        if (!blink_on) begin
            case (mode)
                MODE_SET_HR:  mask = MASK_HOUR;
                MODE_SET_MIN: mask = MASK_MIN;
                default:      mask = MASK_NONE;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Key levels in, time-counter strobes and display mode/blank mask out.
// The slave modport is the controller; the master side is the key scanner plus counter/display.
// All signals are synchronous to the controller clock.
interface clock_ctrl_if;
    import clock_ctrl_pkg::*;

    logic       key_mode;
    logic       key_up;
    logic       key_clr;
    logic       count_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    mode_t      mode;
    logic [5:0] blank_mask;

    modport master (
        output key_mode, key_up, key_clr,
        input  count_en, inc_hour, inc_min, clr_sec, mode, blank_mask
    );

    modport slave (
        input  key_mode, key_up, key_clr,
        output count_en, inc_hour, inc_min, clr_sec, mode, blank_mask
    );

endinterface

// File: rtl/clock_ctrl_key_repeat.sv
// Purpose: rising-edge detect on a key level plus hold-to-repeat pulse generation.
// Latency: fire is combinational from the sampled key; the caller registers it.
// Backpressure: none; the key is sampled every cycle and pulses cannot be stalled.
module clock_ctrl_key_repeat #(
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic en,
    input  logic cancel,
    output logic fire
);
    localparam int CW = $clog2(REPEAT_DLY + 1);
    localparam logic [CW-1:0] CNT_HIT    = CW'(REPEAT_DLY);
    // After each repeat pulse the counter restarts so it reaches CNT_HIT
    // again REPEAT_PER cycles later; assumes REPEAT_PER <= REPEAT_DLY.
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REPEAT_DLY - REPEAT_PER + 1);

    logic          key_prev;
    logic          hist_vld;
    logic          active;
    logic [CW-1:0] cnt;
    logic          press;
    logic          hit;

    // hist_vld keeps a key held through reset release from looking like a press.
    assign press = hist_vld && key && !key_prev;
    assign hit   = active && key && (cnt == CNT_HIT);
    assign fire  = en && !cancel && (press || hit);

    // Key history and hold counter; release, cancel or disable drops the repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_prev <= 1'b0;
            hist_vld <= 1'b0;
            active   <= 1'b0;
            cnt      <= '0;
        end else begin
            key_prev <= key;
            hist_vld <= 1'b1;
            if (!key || cancel || !en) begin
                active <= 1'b0;
                cnt    <= '0;
            end else if (press) begin
                active <= 1'b1;
                cnt    <= CW'(1);
            end else if (hit) begin
                cnt    <= CNT_RELOAD;
            end else if (active) begin
                cnt    <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Purpose: 1 Hz tick, RUN/SET_HR/SET_MIN mode FSM, field strobes and blink mask for HH:MM:SS.
// Latency: every output is registered, one cycle after the edge that samples the key/prescaler.
// Backpressure: none; key levels sampled every cycle, strobes are single-cycle and unstallable.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    clock_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

    mode_t         mode_q;
    mode_t         mode_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          hist_vld;
    logic          mode_prev;
    logic          clr_prev;
    logic          press_mode;
    logic          press_clr;
    logic          leave_set;
    logic          mode_chg;
    logic          up_en;
    logic          up_fire;
    logic          wrap;
    logic          count_en_q, count_en_d;
    logic          inc_hour_q, inc_hour_d;
    logic          inc_min_q,  inc_min_d;
    logic          clr_sec_q,  clr_sec_d;
    logic [5:0]    blank_q,    blank_d;

    assign press_mode = hist_vld && bus.key_mode && !mode_prev;
    assign press_clr  = hist_vld && bus.key_clr  && !clr_prev;
    assign wrap       = (presc_q == PRESC_LAST);
    assign up_en      = (mode_q == MODE_SET_HR) || (mode_q == MODE_SET_MIN);
    // Any mode change, including recovery from the unused encoding, kills a held repeat.
    assign mode_chg   = (mode_d != mode_q);

    clock_ctrl_key_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_key_repeat (
        .clk    (clk),
        .rst    (rst),
        .key    (bus.key_up),
        .en     (up_en),
        .cancel (mode_chg),
        .fire   (up_fire)
    );

    // Key history for the plain edge detectors, armed one edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_vld  <= 1'b0;
            mode_prev <= 1'b0;
            clr_prev  <= 1'b0;
        end else begin
            hist_vld  <= 1'b1;
            mode_prev <= bus.key_mode;
            clr_prev  <= bus.key_clr;
        end
    end

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode sequencing on key_mode presses; leaving SET_MIN restarts the seconds.
    always_comb begin
        mode_d    = mode_q;
        leave_set = 1'b0;
        case (mode_q)
            MODE_RUN:     if (press_mode) mode_d = MODE_SET_HR;
            MODE_SET_HR:  if (press_mode) mode_d = MODE_SET_MIN;
            MODE_SET_MIN: if (press_mode) begin
                mode_d    = MODE_RUN;
                leave_set = 1'b1;
            end
            default:      mode_d = MODE_RUN;
        endcase
    end

    // Next prescaler and strobe values; a seconds clear realigns the prescaler
    // and takes priority over a coincident tick. The blank mask is derived from
    // the next mode/prescaler so it lines up with the registered prescaler.
    always_comb begin
        presc_d    = wrap ? '0 : presc_q + 1'b1;
        count_en_d = wrap && (mode_q == MODE_RUN) && !press_clr;
        clr_sec_d  = press_clr || leave_set;
        inc_hour_d = up_fire && (mode_q == MODE_SET_HR);
        inc_min_d  = up_fire && (mode_q == MODE_SET_MIN);
        if (clr_sec_d) begin
            presc_d = '0;
        end
        blank_d    = blank_for(mode_d, presc_d < PRESC_HALF);
    end

    // Prescaler and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            count_en_q <= 1'b0;
            inc_hour_q <= 1'b0;
            inc_min_q  <= 1'b0;
            clr_sec_q  <= 1'b0;
            blank_q    <= MASK_NONE;
        end else begin
            presc_q    <= presc_d;
            count_en_q <= count_en_d;
            inc_hour_q <= inc_hour_d;
            inc_min_q  <= inc_min_d;
            clr_sec_q  <= clr_sec_d;
            blank_q    <= blank_d;
        end
    end

    assign bus.count_en   = count_en_q;
    assign bus.inc_hour   = inc_hour_q;
    assign bus.inc_min    = inc_min_q;
    assign bus.clr_sec    = clr_sec_q;
    assign bus.mode       = mode_q;
    assign bus.blank_mask = blank_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl with a small tick/repeat configuration.
// A behavioural model predicts every output each cycle; directed steps add literal timing checks.
module tb_clock_ctrl;
    localparam int TD = 10;
    localparam int RD = 6;
    localparam int RP = 3;

    logic clk;
    logic rst;
    clock_ctrl_if bus ();

    clock_ctrl #(.TICK_DIV(TD), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode, m_presc, m_up_held, edge_n;
    bit         m_armed, m_km_prev, m_ku_prev, m_kc_prev;
    bit         e_ce, e_ih, e_im, e_cs;
    int         e_mode;
    logic [5:0] e_mask;

    always @(posedge clk or posedge rst) begin : model
        int nm, np, held;
        bit pm, pu, pc, leave, chg, en, fire;
        if (rst) begin
            m_mode <= 0; m_presc <= 0; m_up_held <= -1; edge_n <= 0;
            m_armed <= 0; m_km_prev <= 0; m_ku_prev <= 0; m_kc_prev <= 0;
            e_ce <= 0; e_ih <= 0; e_im <= 0; e_cs <= 0; e_mode <= 0; e_mask <= 6'd0;
        end else begin
            pm = m_armed && bus.key_mode && !m_km_prev;
            pu = m_armed && bus.key_up   && !m_ku_prev;
            pc = m_armed && bus.key_clr  && !m_kc_prev;
            nm = m_mode;
            leave = 0;
            if (m_mode > 2) nm = 0;
            else if (pm) begin
                nm = (m_mode + 1) % 3;
                leave = (m_mode == 2);
            end
            chg = (nm != m_mode);
            en = (m_mode == 1) || (m_mode == 2);
            // held = edges since the accepted press, -1 when no repeat is live
            held = m_up_held;
            fire = 0;
            if (!bus.key_up || chg || !en) held = -1;
            else if (pu) begin held = 0; fire = 1; end
            else if (held >= 0) begin
                held = held + 1;
                fire = (held >= RD) && ((held - RD) % RP == 0);
            end
            np = (pc || leave) ? 0 : (m_presc + 1) % TD;
            e_ce   <= (m_presc == TD - 1) && (m_mode == 0) && !pc;
            e_cs   <= pc || leave;
            e_ih   <= fire && (m_mode == 1);
            e_im   <= fire && (m_mode == 2);
            e_mode <= nm;
            e_mask <= (np < TD / 2) ? 6'b000000 :
                      (nm == 1) ? 6'b110000 : (nm == 2) ? 6'b001100 : 6'b000000;
            m_mode <= nm; m_presc <= np; m_up_held <= held;
            m_armed <= 1; m_km_prev <= bus.key_mode; m_ku_prev <= bus.key_up; m_kc_prev <= bus.key_clr;
            edge_n <= edge_n + 1;
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    int ce_q[$], hr_q[$], min_q[$], clr_q[$];
    int mask_min_cyc, mask_hr_cyc;

    always @(posedge clk) begin
        #1;
        if (bus.count_en) ce_q.push_back(edge_n);
        if (bus.inc_hour) hr_q.push_back(edge_n);
        if (bus.inc_min)  min_q.push_back(edge_n);
        if (bus.clr_sec)  clr_q.push_back(edge_n);
        if (bus.blank_mask == 6'b001100) mask_min_cyc++;
        if (bus.blank_mask == 6'b110000) mask_hr_cyc++;
        chk("count_en",   32'(bus.count_en),   32'(e_ce));
        chk("inc_hour",   32'(bus.inc_hour),   32'(e_ih));
        chk("inc_min",    32'(bus.inc_min),    32'(e_im));
        chk("clr_sec",    32'(bus.clr_sec),    32'(e_cs));
        chk("mode",       32'(bus.mode),       32'(e_mode));
        chk("blank_mask", 32'(bus.blank_mask), 32'(e_mask));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        ce_q.delete(); hr_q.delete(); min_q.delete(); clr_q.delete();
        mask_min_cyc = 0; mask_hr_cyc = 0;
    endtask

    // One key_mode press; pe returns the edge that samples it.
    task automatic pulse_mode(output int pe);
        bus.key_mode = 1'b1;
        @(negedge clk);
        pe = edge_n;
        bus.key_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_count_en"}, 32'(bus.count_en), 32'd0);
        chk({tag, "_inc_hour"}, 32'(bus.inc_hour), 32'd0);
        chk({tag, "_inc_min"},  32'(bus.inc_min),  32'd0);
        chk({tag, "_clr_sec"},  32'(bus.clr_sec),  32'd0);
        chk({tag, "_mode"},     32'(bus.mode),     32'd0);
        chk({tag, "_blank"},    32'(bus.blank_mask), 32'd0);
    endtask

    int rep_offs[4] = '{0, 6, 9, 12};

    initial begin : stim
        int pe, p, q, u;
        clk = 1'b0;
        rst = 1'b1;
        bus.key_mode = 1'b0;
        bus.key_up   = 1'b0;
        bus.key_clr  = 1'b0;
        cyc(2);
        chk_outputs_zero("reset");
        rst = 1'b0;
        clear_log();

        // 1: free run, ticks after edges 10, 20, 30
        cyc(35);
        chk("t1_ce_count", 32'(ce_q.size()), 32'd3);
        chk("t1_ce0", 32'(ce_q[0]), 32'd10);
        chk("t1_ce1", 32'(ce_q[1]), 32'd20);
        chk("t1_ce2", 32'(ce_q[2]), 32'd30);
        chk("t1_mask_cycles", 32'(mask_min_cyc + mask_hr_cyc), 32'd0);

        // 2: mode cycling, SET_MIN->RUN clears seconds and realigns the tick
        clear_log();
        pulse_mode(pe);
        chk("t2_mode_a", 32'(bus.mode), 32'd1);
        pulse_mode(pe);
        chk("t2_mode_b", 32'(bus.mode), 32'd2);
        pulse_mode(q);
        chk("t2_mode_c", 32'(bus.mode), 32'd0);
        cyc(12);
        chk("t2_clr_count", 32'(clr_q.size()), 32'd1);
        chk("t2_clr_edge", 32'(clr_q[0]), 32'(q));
        chk("t2_ce_count", 32'(ce_q.size()), 32'd1);
        chk("t2_ce_edge", 32'(ce_q[0]), 32'(q + 10));

        // 3: SET_HR, hold key_up 15 cycles -> strobes at +0, +6, +9, +12
        pulse_mode(pe);
        clear_log();
        bus.key_up = 1'b1;
        @(negedge clk);
        p = edge_n;
        cyc(14);
        bus.key_up = 1'b0;
        cyc(3);
        chk("t3_hr_count", 32'(hr_q.size()), 32'd4);
        foreach (rep_offs[i]) chk("t3_hr_edge", 32'(hr_q[i]), 32'(p + rep_offs[i]));
        chk("t3_min_count", 32'(min_q.size()), 32'd0);
        chk("t3_ce_count", 32'(ce_q.size()), 32'd0);

        // 4: SET_MIN blink, half of any 20 cycles blanked, no ticks
        pulse_mode(pe);
        clear_log();
        cyc(20);
        chk("t4_mask_min_cyc", 32'(mask_min_cyc), 32'd10);
        chk("t4_mask_hr_cyc", 32'(mask_hr_cyc), 32'd0);
        chk("t4_ce_count", 32'(ce_q.size()), 32'd0);

        // 5a: key_mode and key_up together in SET_HR -> SET_MIN, no strobe, no repeat
        pulse_mode(pe);
        pulse_mode(pe);
        chk("t5_mode_hr", 32'(bus.mode), 32'd1);
        clear_log();
        bus.key_mode = 1'b1;
        bus.key_up   = 1'b1;
        @(negedge clk);
        bus.key_mode = 1'b0;
        cyc(10);
        bus.key_up = 1'b0;
        cyc(1);
        chk("t5_mode_min", 32'(bus.mode), 32'd2);
        chk("t5_inc_count", 32'(hr_q.size() + min_q.size()), 32'd0);

        // 5b: key_clr at prescaler 9 in RUN -> clr_sec, tick suppressed
        pulse_mode(q);
        clear_log();
        cyc(8);
        bus.key_clr = 1'b1;
        @(negedge clk);
        bus.key_clr = 1'b0;
        cyc(12);
        chk("t5_clr_count", 32'(clr_q.size()), 32'd1);
        chk("t5_clr_edge", 32'(clr_q[0]), 32'(q + 10));
        chk("t5_ce_count", 32'(ce_q.size()), 32'd1);
        chk("t5_ce_edge", 32'(ce_q[0]), 32'(q + 20));

        // 6: reset in SET_MIN with key_up held
        pulse_mode(pe);
        pulse_mode(pe);
        clear_log();
        bus.key_up = 1'b1;
        @(negedge clk);
        u = edge_n;
        chk("t6_inc_min_pre", 32'(bus.inc_min), 32'd1);
        chk("t6_min_edge", 32'(min_q[0]), 32'(u));
        rst = 1'b1;
        bus.key_mode = 1'b1;
        #1;
        chk_outputs_zero("t6_rst");
        cyc(2);
        clear_log();
        rst = 1'b0;
        cyc(6);
        chk("t6_mode_held_key", 32'(bus.mode), 32'd0);
        bus.key_mode = 1'b0;
        cyc(1);
        pulse_mode(pe);
        cyc(8);
        chk("t6_mode_hr", 32'(bus.mode), 32'd1);
        chk("t6_no_strobe", 32'(hr_q.size() + min_q.size()), 32'd0);
        bus.key_up = 1'b0;
        cyc(1);
        bus.key_up = 1'b1;
        @(negedge clk);
        p = edge_n;
        bus.key_up = 1'b0;
        cyc(2);
        chk("t6_new_press_count", 32'(hr_q.size()), 32'd1);
        chk("t6_new_press_edge", 32'(hr_q[0]), 32'(p));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
